// File: rtl/ula_ctrl.sv
// ula_ctrl: three-state sequencer (IDLE/EXEC/DONE) wrapped around an external 8-bit ALU.
// Optional status flags res_zero/res_neg are compiled in with `define ULA_CTRL_FLAGS_EN.
module ula_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_x,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [7:0] op_count
`ifdef ULA_CTRL_FLAGS_EN
  ,
  output logic       res_zero,
  output logic       res_neg
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_reg, state_next;
  logic [7:0] acc_reg;
  logic [7:0] opnd_reg;
  logic [2:0] opc_reg;
  logic       load_reg;
  logic [7:0] cnt_reg;
  logic       accept;
  logic [7:0] acc_next;

  assign cmd_ready = (state_reg == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign res_valid = (state_reg == DONE);
  assign res_data  = acc_reg;
  assign alu_a     = acc_reg;
  assign alu_b     = opnd_reg;
  assign alu_op    = opc_reg;
  assign op_count  = cnt_reg;

  // Value the accumulator takes at the end of EXEC.
  assign acc_next = load_reg ? opnd_reg : alu_x;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= 8'h00;
      opnd_reg  <= 8'h00;
      opc_reg   <= 3'b000;
      load_reg  <= 1'b0;
      cnt_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        load_reg <= cmd_load;
        opc_reg  <= cmd_op;
        opnd_reg <= cmd_data;
      end
      if (state_reg == EXEC) begin
        acc_reg <= acc_next;
        // Loads do not count; the counter sticks at 0xFF.
        if (!load_reg && (cnt_reg != 8'hFF))
          cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

`ifdef ULA_CTRL_FLAGS_EN
  logic zero_reg, neg_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else if (state_reg == EXEC) begin
      zero_reg <= (acc_next == 8'h00);
      neg_reg  <= acc_next[7];
    end
  end

  assign res_zero = zero_reg;
  assign res_neg  = neg_reg;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed self-checking bench for ula_ctrl; a behavioural ALU closes the alu_a/alu_b/alu_op -> alu_x loop.
module tb_ula_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] alu_a, alu_b, alu_x;
  logic [2:0] alu_op;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [7:0] op_count;
`ifdef ULA_CTRL_FLAGS_EN
  logic       res_zero, res_neg;
`endif

  int total  = 0;
  int passed = 0;

  ula_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_x(alu_x),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .op_count(op_count)
`ifdef ULA_CTRL_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  always #5 clk = ~clk;

  // External ALU the controller drives.
  always_comb begin
    alu_x = 8'h00;
    case (alu_op)
      3'b000: alu_x = alu_a | alu_b;
      3'b001: alu_x = alu_a & alu_b;
      3'b010: alu_x = alu_a ^ alu_b;
      3'b011: alu_x = ~alu_a;
      3'b100: alu_x = alu_a + alu_b;
      3'b101: alu_x = alu_a - alu_b;
      3'b110: alu_x = alu_a + 8'd1;
      3'b111: alu_x = alu_b + 8'd1;
      default: alu_x = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: got %02h expected %02h", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command with res_ready high; returns in the first IDLE cycle afterwards.
  task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [7:0] d,
                          input logic [7:0] exp, input bit verbose);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_data  = d;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (verbose) begin
      chk("exec_res_valid", {7'b0, res_valid}, 8'h00);
      chk("exec_cmd_ready", {7'b0, cmd_ready}, 8'h00);
    end
    tick();
    if (verbose) begin
      chk("done_res_valid", {7'b0, res_valid}, 8'h01);
      chk("done_res_data", res_data, exp);
    end
    tick();
  endtask

  initial begin
    // Reset state while rst is held high
    #2;
    chk("rst_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    chk("rst_res_valid", {7'b0, res_valid}, 8'h00);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_op_count", op_count, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_op", {5'b0, alu_op}, 8'h00);
`ifdef ULA_CTRL_FLAGS_EN
    chk("rst_res_zero", {7'b0, res_zero}, 8'h00);
    chk("rst_res_neg", {7'b0, res_neg}, 8'h00);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Load then ADD
    send_cmd(1'b1, 3'b000, 8'h05, 8'h05, 1'b1);
    chk("load_op_count", op_count, 8'h00);
    send_cmd(1'b0, 3'b100, 8'h03, 8'h08, 1'b1);
    chk("add_op_count", op_count, 8'h01);
    chk("add_alu_b", alu_b, 8'h03);
    chk("add_alu_op", {5'b0, alu_op}, 8'h04);

    // SUB wraps below zero
    send_cmd(1'b0, 3'b101, 8'h09, 8'hFF, 1'b1);
`ifdef ULA_CTRL_FLAGS_EN
    chk("sub_res_neg", {7'b0, res_neg}, 8'h01);
    chk("sub_res_zero", {7'b0, res_zero}, 8'h00);
`endif

    // a+1 wraps above 0xFF
    send_cmd(1'b1, 3'b000, 8'hFF, 8'hFF, 1'b1);
    send_cmd(1'b0, 3'b110, 8'h00, 8'h00, 1'b1);
`ifdef ULA_CTRL_FLAGS_EN
    chk("inc_res_zero", {7'b0, res_zero}, 8'h01);
    chk("inc_res_neg", {7'b0, res_neg}, 8'h00);
`endif

    // OR with consumer stalled for 5 cycles while a new command is offered
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 8'h0F;
    res_ready = 1'b0;
    tick();
    cmd_data  = 8'hAA;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_res_valid", {7'b0, res_valid}, 8'h01);
      chk("stall_res_data", res_data, 8'h0F);
      chk("stall_cmd_ready", {7'b0, cmd_ready}, 8'h00);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("release_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    chk("release_res_valid", {7'b0, res_valid}, 8'h00);
    chk("release_res_data", res_data, 8'h0F);
    cmd_valid = 1'b0;
    tick();

    // Remaining logic ops
    send_cmd(1'b0, 3'b010, 8'hFF, 8'hF0, 1'b1);
    send_cmd(1'b0, 3'b001, 8'h3C, 8'h30, 1'b1);
    send_cmd(1'b0, 3'b011, 8'h00, 8'hCF, 1'b1);
    send_cmd(1'b0, 3'b111, 8'h7F, 8'h80, 1'b1);
`ifdef ULA_CTRL_FLAGS_EN
    chk("binc_res_neg", {7'b0, res_neg}, 8'h01);
`endif
    chk("ops_op_count", op_count, 8'h08);

    // Reset pulsed in the middle of EXEC
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_op    = 3'b100;
    cmd_data  = 8'h01;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("mid_rst_acc", alu_a, 8'h00);
    chk("mid_rst_op_count", op_count, 8'h00);
    chk("mid_rst_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_res_valid", {7'b0, res_valid}, 8'h00);
    end
    send_cmd(1'b1, 3'b000, 8'h11, 8'h11, 1'b1);

    // Saturation of op_count over 256 ADD +1 operations
    for (int i = 1; i <= 256; i++) begin
      send_cmd(1'b0, 3'b100, 8'h01, 8'h00, 1'b0);
      if (i == 254) chk("sat_254", op_count, 8'hFE);
      if (i == 255) chk("sat_255", op_count, 8'hFF);
    end
    chk("sat_256", op_count, 8'hFF);
    chk("sat_acc_wrap", res_data, 8'h11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
